// File: rtl/axi_dma_mm2s_ar_gen.sv
// axi_dma_mm2s_ar_gen: splits MM2S commands into AXI4 read bursts (4KB- and length-limited)
// and emits a per-burst info word for the R-channel unpacker on a 32-bit data bus.
module axi_dma_mm2s_ar_gen #(
    parameter int  MAX_BURST_LEN = 16,
    parameter real SIM_DELAY     = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [55:0] s_cmd_axis_data,
    input  logic        s_cmd_axis_user,
    input  logic        s_cmd_axis_last,
    input  logic        s_cmd_axis_valid,
    output logic        s_cmd_axis_ready,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic [3:0]  m_axi_arcache,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic [5:0]  m_info_axis_data,
    output logic        m_info_axis_valid,
    input  logic        m_info_axis_ready
);
    typedef enum logic [2:0] {S_IDLE = 3'b001, S_CALC = 3'b010, S_ISSUE = 3'b100} state_t;

    localparam logic [10:0] L_CAP_INCR  = 11'(MAX_BURST_LEN);
    localparam logic [10:0] L_CAP_FIXED = (MAX_BURST_LEN > 16) ? 11'd16 : 11'(MAX_BURST_LEN);

    // Elaboration-time sanity hooks; no hardware is generated by either.
    if (MAX_BURST_LEN < 1 || MAX_BURST_LEN > 256) begin : g_bad_burst_len
    end
    if (SIM_DELAY < 0.0) begin : g_bad_sim_delay
    end

    state_t      r_state;
    logic [31:0] r_addr;
    logic [23:0] r_bytes;
    logic [1:0]  r_head;
    logic [1:0]  r_tail;
    logic        r_fixed;
    logic        r_last;
    logic [22:0] r_beats_left;
    logic        r_arvalid;
    logic [31:0] r_araddr;
    logic [7:0]  r_arlen;
    logic        r_info_valid;
    logic [5:0]  r_info_data;

    logic        w_calc;
    logic        w_issue;
    logic [22:0] w_total;
    logic [22:0] w_rem;
    logic [10:0] w_4k;
    logic [10:0] w_cap;
    logic [10:0] w_lim;
    logic [10:0] w_beats;
    logic [22:0] w_rem_next;
    logic        w_last_burst;
    logic        w_both_done;
    logic        w_load;

    assign w_calc       = r_state == S_CALC;
    assign w_issue      = r_state == S_ISSUE;
    assign w_total      = 23'(({23'd0, r_head} + {1'b0, r_bytes} + 25'd3) >> 2);
    assign w_rem        = w_calc ? w_total : r_beats_left;
    // Fixed bursts never cross memory, so only incrementing bursts honour the 4KB limit.
    assign w_4k         = 11'd1024 - {1'b0, r_addr[11:2]};
    assign w_cap        = r_fixed ? L_CAP_FIXED : L_CAP_INCR;
    assign w_lim        = (!r_fixed && w_4k < w_cap) ? w_4k : w_cap;
    assign w_beats      = (w_rem < {12'd0, w_lim}) ? w_rem[10:0] : w_lim;
    assign w_rem_next   = w_rem - {12'd0, w_beats};
    assign w_last_burst = w_rem_next == 23'd0;
    assign w_both_done  = (!r_arvalid || m_axi_arready) && (!r_info_valid || m_info_axis_ready);
    assign w_load       = (w_calc && r_bytes != 24'd0) || (w_issue && w_both_done && r_beats_left != 23'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_bytes      <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_fixed      <= 1'b0;
            r_last       <= 1'b0;
            r_beats_left <= '0;
            r_arvalid    <= 1'b0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_info_valid <= 1'b0;
            r_info_data  <= '0;
        end else begin
            if (r_arvalid && m_axi_arready) r_arvalid <= 1'b0;
            if (r_info_valid && m_info_axis_ready) r_info_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: if (s_cmd_axis_valid) begin
                    r_addr  <= {s_cmd_axis_data[31:2], 2'b00};
                    r_bytes <= s_cmd_axis_data[55:32];
                    r_head  <= s_cmd_axis_data[1:0];
                    r_tail  <= s_cmd_axis_data[1:0] + s_cmd_axis_data[33:32] - 2'd1;
                    r_fixed <= s_cmd_axis_user;
                    r_last  <= s_cmd_axis_last;
                    r_state <= S_CALC;
                end
                S_CALC:  r_state <= (r_bytes == 24'd0) ? S_IDLE : S_ISSUE;
                S_ISSUE: if (w_both_done && r_beats_left == 23'd0) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_load) begin
                r_arvalid    <= 1'b1;
                r_info_valid <= 1'b1;
                r_araddr     <= r_addr;
                r_arlen      <= 8'(w_beats - 11'd1);
                r_addr       <= r_fixed ? r_addr : r_addr + {19'd0, w_beats, 2'b00};
                r_beats_left <= w_rem_next;
                r_info_data  <= {w_last_burst, w_last_burst & r_last,
                                 w_calc ? r_head : 2'b00, w_last_burst ? r_tail : 2'b11};
            end
        end
    end

    assign s_cmd_axis_ready  = r_state == S_IDLE;
    assign m_axi_araddr      = r_araddr;
    assign m_axi_arlen       = r_arlen;
    assign m_axi_arsize      = 3'b010;
    assign m_axi_arburst     = r_fixed ? 2'b00 : 2'b01;
    assign m_axi_arcache     = 4'b0011;
    assign m_axi_arprot      = 3'b000;
    assign m_axi_arvalid     = r_arvalid;
    assign m_info_axis_data  = r_info_data;
    assign m_info_axis_valid = r_info_valid;
endmodule

// File: tb/tb_axi_dma_mm2s_ar_gen.sv
// tb_axi_dma_mm2s_ar_gen: directed commands with hand-computed AR/info expectations,
// checked by a negedge scoreboard monitor decoupled from the stimulus.
module tb_axi_dma_mm2s_ar_gen;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [55:0] s_cmd_axis_data = '0;
    logic        s_cmd_axis_user = 1'b0;
    logic        s_cmd_axis_last = 1'b0;
    logic        s_cmd_axis_valid = 1'b0;
    logic        s_cmd_axis_ready;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b1;
    logic [5:0]  m_info_axis_data;
    logic        m_info_axis_valid;
    logic        m_info_axis_ready = 1'b1;

    axi_dma_mm2s_ar_gen #(.MAX_BURST_LEN(16)) dut (
        .clk(clk), .resetn(resetn),
        .s_cmd_axis_data(s_cmd_axis_data), .s_cmd_axis_user(s_cmd_axis_user),
        .s_cmd_axis_last(s_cmd_axis_last), .s_cmd_axis_valid(s_cmd_axis_valid),
        .s_cmd_axis_ready(s_cmd_axis_ready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_info_axis_data(m_info_axis_data), .m_info_axis_valid(m_info_axis_valid),
        .m_info_axis_ready(m_info_axis_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [41:0] ar_q[$];
    logic [5:0]  info_q[$];
    int          acc_cyc = 0;
    bit          wait_first = 0;
    bit          seen_valid = 0;
    int          info_cnt = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    initial begin
        bit          ar_pend = 0;
        bit          in_pend = 0;
        logic [41:0] ar_prev = '0;
        logic [5:0]  in_prev = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                ar_pend = 0;
                in_pend = 0;
            end else begin
                if (m_axi_arvalid || m_info_axis_valid) seen_valid = 1;
                if (m_info_axis_valid) info_cnt++;
                if (wait_first && m_axi_arvalid) begin
                    check("ar_latency", 64'(cyc - acc_cyc), 64'd2);
                    wait_first = 0;
                end
                if (ar_pend)
                    check("ar_stable", {m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arburst}, {1'b1, ar_prev});
                if (in_pend)
                    check("info_stable", {m_info_axis_valid, m_info_axis_data}, {1'b1, in_prev});
                ar_pend = m_axi_arvalid && !m_axi_arready;
                ar_prev = {m_axi_araddr, m_axi_arlen, m_axi_arburst};
                in_pend = m_info_axis_valid && !m_info_axis_ready;
                in_prev = m_info_axis_data;
                if (m_axi_arvalid && m_axi_arready) begin
                    check("ar_const", {m_axi_arsize, m_axi_arcache, m_axi_arprot}, {3'b010, 4'b0011, 3'b000});
                    if (ar_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL ar_unexpected: got %0h expected no burst", {m_axi_araddr, m_axi_arlen, m_axi_arburst});
                    end else check("ar_burst", {m_axi_araddr, m_axi_arlen, m_axi_arburst}, ar_q.pop_front());
                end
                if (m_info_axis_valid && m_info_axis_ready) begin
                    if (info_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL info_unexpected: got %0h expected no info", m_info_axis_data);
                    end else check("info_data", m_info_axis_data, info_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [23:0] b, input logic u, input logic l, input bit exp);
        int n = 0;
        s_cmd_axis_data  = {b, a};
        s_cmd_axis_user  = u;
        s_cmd_axis_last  = l;
        s_cmd_axis_valid = 1'b1;
        do begin @(negedge clk); n++; end while (!s_cmd_axis_ready && n < 100);
        check("cmd_accept_timeout", 64'(n < 100), 64'd1);
        acc_cyc    = cyc;
        wait_first = exp;
        @(posedge clk); #1;
        s_cmd_axis_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(ar_q.size() == 0 && info_q.size() == 0 && s_cmd_axis_ready) && n < 300);
        check("done_timeout", 64'(n < 300), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("rst_info_valid", 64'(m_info_axis_valid), 64'd0);
        check("rst_cmd_ready", 64'(s_cmd_axis_ready), 64'd1);
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;

        // Single 16-beat burst
        ar_q.push_back({32'h1000_0000, 8'd15, 2'b01}); info_q.push_back(6'b110011);
        send(32'h1000_0000, 24'd64, 1'b0, 1'b1, 1); wait_done();

        // 4KB crossing split
        ar_q.push_back({32'h0000_0FF8, 8'd1, 2'b01}); ar_q.push_back({32'h0000_1000, 8'd1, 2'b01});
        info_q.push_back(6'b000011); info_q.push_back(6'b100011);
        send(32'h0000_0FF8, 24'd16, 1'b0, 1'b0, 1); wait_done();

        // Unaligned head and partial tail
        ar_q.push_back({32'h0000_2000, 8'd1, 2'b01}); info_q.push_back(6'b101010);
        send(32'h0000_2002, 24'd5, 1'b0, 1'b0, 1); wait_done();

        // Fixed-address, capped at 16 beats
        ar_q.push_back({32'h0000_3000, 8'd15, 2'b00}); ar_q.push_back({32'h0000_3000, 8'd15, 2'b00});
        info_q.push_back(6'b000011); info_q.push_back(6'b110011);
        send(32'h0000_3000, 24'd128, 1'b1, 1'b1, 1); wait_done();

        // Zero-byte command is swallowed
        seen_valid = 0;
        send(32'h0000_5000, 24'd0, 1'b0, 1'b1, 0);
        @(negedge clk); check("zero_calc_ready", 64'(s_cmd_axis_ready), 64'd0);
        @(negedge clk); check("zero_ready_back", 64'(s_cmd_axis_ready), 64'd1);
        repeat (3) @(negedge clk);
        check("zero_no_valid", 64'(seen_valid), 64'd0);
        @(posedge clk); #1;

        // arready held low: info pulses once, AR holds, second burst waits
        m_axi_arready = 1'b0; info_cnt = 0;
        ar_q.push_back({32'h0000_0FF8, 8'd1, 2'b01}); ar_q.push_back({32'h0000_1000, 8'd1, 2'b01});
        info_q.push_back(6'b000011); info_q.push_back(6'b110011);
        send(32'h0000_0FF8, 24'd16, 1'b0, 1'b1, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!m_axi_arvalid && n < 20);
        repeat (5) @(negedge clk);
        check("stall_info_pulses", 64'(info_cnt), 64'd1);
        check("stall_ar_held", {m_axi_arvalid, m_axi_araddr, m_axi_arlen}, {1'b1, 32'h0000_0FF8, 8'd1});
        @(posedge clk); #1 m_axi_arready = 1'b1;
        wait_done();
        check("stall_info_total", 64'(info_cnt), 64'd2);

        // Reset during the second burst
        ar_q.push_back({32'h0000_4000, 8'd15, 2'b01});
        info_q.push_back(6'b000011); info_q.push_back(6'b000011);
        send(32'h0000_4000, 24'd256, 1'b0, 1'b0, 1);
        n = 0;
        while (!(m_axi_arvalid && m_axi_araddr == 32'h0000_4040) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        m_axi_arready = 1'b0;
        check("rst_mid_second_burst", 64'(n < 100), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1 resetn = 1'b0;
        #1;
        check("rst_mid_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("rst_mid_cmd_ready", 64'(s_cmd_axis_ready), 64'd1);
        check("rst_mid_queues", 64'(ar_q.size() + info_q.size()), 64'd0);
        @(posedge clk); #1 resetn = 1'b1; m_axi_arready = 1'b1;
        @(posedge clk); #1;
        ar_q.push_back({32'h1000_0000, 8'd15, 2'b01}); info_q.push_back(6'b110011);
        send(32'h1000_0000, 24'd64, 1'b0, 1'b1, 1); wait_done();

        check("final_queues_empty", 64'(ar_q.size() + info_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi_dma_mm2s_ar_gen.md
AXI_DMA_MM2S_AR_GEN -- requirements
Module: axi_dma_mm2s_ar_gen

Interface
REQ-001 SHALL have parameter MAX_BURST_LEN, default 16, meaning the maximum beats per AXI read burst (legal range 1..256).
REQ-002 SHALL have parameter SIM_DELAY (real), default 1, meaning the simulation delay applied to register updates.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have the MM2S command AXIS slave:
- s_cmd_axis_data, input, 56 bits: {bytes to transfer [55:32], start address [31:0]}.
- s_cmd_axis_user, input, 1 bit: 1 = fixed-address transfer, 0 = incrementing.
- s_cmd_axis_last, input, 1 bit: frame last.
- s_cmd_axis_valid, input, 1 bit.
- s_cmd_axis_ready, output, 1 bit.
REQ-006 SHALL have the AXI4 read address master:
- m_axi_araddr, output, 32 bits.
- m_axi_arlen, output, 8 bits.
- m_axi_arsize, output, 3 bits: constant 3'b010.
- m_axi_arburst, output, 2 bits.
- m_axi_arcache, output, 4 bits: constant 4'b0011.
- m_axi_arprot, output, 3 bits: constant 3'b000.
- m_axi_arvalid, output, 1 bit.
- m_axi_arready, input, 1 bit.
REQ-007 SHALL have the burst-info AXIS master for the R-channel unpacker:
- m_info_axis_data, output, 6 bits: {last_of_cmd, frame_last, head_ofs[1:0], tail_bytes_sub1[1:0]}.
- m_info_axis_valid, output, 1 bit.
- m_info_axis_ready, input, 1 bit.

Function
REQ-008 SHALL assume a fixed 32-bit data bus, so 4 bytes per beat.
REQ-009 SHALL use a one-hot FSM with three states:
- IDLE: s_cmd_axis_ready=1; on command handshake go to CALC.
- CALC: lasts one cycle; go to ISSUE, or to IDLE if the byte count is 0.
- ISSUE: go to IDLE when the final burst has completed both handshakes.
REQ-010 In CALC the block SHALL compute:
- aligned address = addr & ~3;
- total beats = (addr[1:0] + bytes + 3) >> 2, held in a 23-bit counter;
- head_ofs = addr[1:0];
- tail_bytes_sub1 = (addr[1:0] + bytes - 1)[1:0].
REQ-011 Each burst's beats SHALL equal min(remaining beats, MAX_BURST_LEN, beats to 4KB boundary = 1024 - addr[11:2]), and arlen SHALL equal beats - 1.
REQ-012 For fixed transfers (user=1):
- arburst=2'b00;
- the address SHALL NOT advance;
- the 4KB limit SHALL NOT apply;
- the burst cap SHALL be min(MAX_BURST_LEN, 16).
REQ-013 For incrementing transfers, arburst=2'b01 and the address SHALL advance by beats*4 after each burst.
REQ-014 In ISSUE, arvalid and info valid SHALL assert together for each burst, and each SHALL deassert independently after its own handshake.
REQ-015 The next burst SHALL start only once both handshakes of the current burst have completed.
REQ-016 araddr, arlen, arburst and info data SHALL remain stable while the corresponding valid is high and unacknowledged.
REQ-017 Info fields per burst:
- head_ofs: nonzero only in the first burst, 0 otherwise;
- tail_bytes_sub1: meaningful only in the last burst, 3 otherwise;
- last_of_cmd: 1 only in the last burst;
- frame_last: registered s_cmd_axis_last, carried only in the last burst, 0 otherwise.
REQ-018 Latency: for a command accepted at cycle N, the first arvalid SHALL be high at cycle N+2.
REQ-019 After the final burst's handshakes complete, s_cmd_axis_ready SHALL be high in the next cycle.
REQ-020 A command with a byte count of 0 SHALL be accepted and discarded: no AR or info transfer, and a return to IDLE from CALC.
REQ-021 arvalid SHALL NOT depend combinationally on arready or on m_info_axis_ready.

Reset
REQ-022 While resetn=0, the state SHALL be IDLE, with m_axi_arvalid=0, m_info_axis_valid=0 and s_cmd_axis_ready=1.
REQ-023 Reset asserted mid-ISSUE SHALL abort the command with no further bursts; the next command after reset SHALL start cleanly.

Verification
REQ-024 Command addr 0x1000_0000, bytes 64, incr, last=1 -> one AR with araddr 0x1000_0000, arlen 15, arburst 01; info {1,1,00,11}.
REQ-025 Command addr 0x0000_0FF8, bytes 16, incr -> two ARs: 0x0FF8 with arlen 1, then 0x1000 with arlen 1; last_of_cmd 0 then 1.
REQ-026 Command addr 0x2002, bytes 5, last=0 -> one AR with araddr 0x2000, arlen 1; info {1,0,10,10}.
REQ-027 Command addr 0x3000, bytes 128, user=1 -> two ARs, both with araddr 0x3000, arlen 15, arburst 00.
REQ-028 Bytes 0 -> no arvalid and no info valid; s_cmd_axis_ready high 2 cycles after acceptance.
REQ-029 Hold arready low for 5 cycles with info ready high -> info valid pulses one cycle, araddr and arlen stay stable, and the second burst starts only after the AR handshake.
REQ-030 Reset during the second burst -> arvalid drops immediately, s_cmd_axis_ready=1, and the next command completes normally.
